// File: rtl/har_nn_driver_pkg.sv
// Shared types and default widths for the HAR neural-network port driver.
// The topNN integration imports the same package.
package har_nn_pkg;

  localparam int unsigned NN_IN_WIDTH     = 16;
  localparam int unsigned NN_WEIGHT_WIDTH = 16;
  localparam int unsigned NN_NUM_WEIGHTS  = 563;
  localparam int unsigned NN_TIMEOUT      = 4096;
  localparam int unsigned NN_FEAT_W       = (NN_IN_WIDTH - 1) * NN_WEIGHT_WIDTH;
  localparam int unsigned NN_RES_MAX_W    = 16;
  localparam int unsigned NN_RES_IDX_W    = 3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD_W   = 3'd1,
    ST_READY    = 3'd2,
    ST_SEND_F   = 3'd3,
    ST_WAIT_RES = 3'd4,
    ST_HOLD_RES = 3'd5
  } nn_state_t;

  typedef struct packed {
    logic [NN_RES_MAX_W-1:0] value;
    logic [NN_RES_IDX_W-1:0] index;
  } nn_result_t;

endpackage

// File: rtl/har_nn_driver_if.sv
// Host-to-NN port bundle: weight/feature beats out, flow control and result in.
interface har_nn_driver_if
  import har_nn_pkg::*;
#(
  parameter int unsigned FEAT_W = NN_FEAT_W,
  parameter int unsigned WGT_W  = NN_WEIGHT_WIDTH
) ();

  logic [WGT_W-1:0]        weight;
  logic                    weight_valid_NN;
  logic [FEAT_W-1:0]       feature;
  logic                    feature_valid_NN;
  logic                    NN_busy;
  logic                    waiting_weight_NN;
  logic                    output_valid_NN;
  logic [NN_RES_MAX_W-1:0] max_out_NN;
  logic [NN_RES_IDX_W-1:0] maxindex_out_NN;

  modport master (
    output weight, weight_valid_NN, feature, feature_valid_NN,
    input  NN_busy, waiting_weight_NN, output_valid_NN, max_out_NN, maxindex_out_NN
  );

  modport slave (
    input  weight, weight_valid_NN, feature, feature_valid_NN,
    output NN_busy, waiting_weight_NN, output_valid_NN, max_out_NN, maxindex_out_NN
  );

endinterface

// File: rtl/har_nn_driver_timeout_cnt.sv
// Inference watchdog: cleared by load, counts while enabled, saturates at TIMEOUT-1.
module har_nn_timeout_cnt #(
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic expired_c
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] cnt;

  assign expired_c = (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (en && !expired_c) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/har_nn_driver.sv
// Sequencer driving the HAR NN port: streams the weight load, issues feature
// vectors one at a time and holds each (max, argmax) result for the consumer.
module har_nn_driver
  import har_nn_pkg::*;
#(
  parameter int unsigned inWidth     = NN_IN_WIDTH,
  parameter int unsigned weightWidth = NN_WEIGHT_WIDTH,
  parameter int unsigned NUM_WEIGHTS = NN_NUM_WEIGHTS,
  parameter int unsigned TIMEOUT     = NN_TIMEOUT
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              load_start,
  input  logic [weightWidth-1:0]            w_in_data,
  input  logic                              w_in_valid,
  output logic                              w_in_ready,
  input  logic [(inWidth-1)*weightWidth-1:0] feat_in_data,
  input  logic                              feat_in_valid,
  output logic                              feat_in_ready,
  har_nn_driver_if.master                   nn,
  output logic [NN_RES_MAX_W-1:0]           result_max,
  output logic [NN_RES_IDX_W-1:0]           result_index,
  output logic                              result_valid,
  input  logic                              result_ready,
  output logic                              weights_loaded,
  output logic                              timeout_err
);

  localparam int unsigned WCNT_W = $clog2(NUM_WEIGHTS + 1);
  localparam int unsigned FEAT_W = (inWidth - 1) * weightWidth;

  nn_state_t          state, state_nx;
  logic [WCNT_W-1:0]  wcnt;
  logic               load_pend;
  logic               start_load;
  logic               w_hs, f_hs, last_w, res_cap, tmo_exp_c;
  logic [weightWidth-1:0] weight_q;
  logic               weight_valid_q;
  logic [FEAT_W-1:0]  feature_q;
  logic               feature_valid_q;
  nn_result_t         result_q;

  assign w_hs    = w_in_valid && w_in_ready;
  assign f_hs    = feat_in_valid && feat_in_ready;
  assign last_w  = w_hs && (wcnt == WCNT_W'(NUM_WEIGHTS - 1));
  assign res_cap = (state == ST_WAIT_RES) && nn.output_valid_NN;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic; a (re)load request pre-empts everything it is allowed to
  always_comb begin
    state_nx = state;
    if (start_load) begin
      state_nx = ST_LOAD_W;
    end else begin
      case (state)
        ST_IDLE:     state_nx = ST_IDLE;
        ST_LOAD_W:   if (last_w) state_nx = ST_READY;
        ST_READY:    if (f_hs) state_nx = ST_SEND_F;
        ST_SEND_F:   state_nx = ST_WAIT_RES;
        ST_WAIT_RES: begin
          if (nn.output_valid_NN) state_nx = ST_HOLD_RES;
          else if (tmo_exp_c)     state_nx = ST_READY;
        end
        ST_HOLD_RES: if (result_ready) state_nx = ST_READY;
        default:     state_nx = ST_IDLE;
      endcase
    end
  end

  // Upstream readies and load request; load_start masks readies so no beat is lost
  always_comb begin
    w_in_ready    = 1'b0;
    feat_in_ready = 1'b0;
    start_load    = load_start;
    if (state == ST_HOLD_RES) start_load = result_ready && (load_pend || load_start);
    if (state == ST_LOAD_W)   w_in_ready = nn.waiting_weight_NN && !load_start;
    if (state == ST_READY)
      feat_in_ready = !nn.NN_busy && !nn.waiting_weight_NN && !load_start;
  end

  // Registered datapath and status
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wcnt            <= '0;
      load_pend       <= 1'b0;
      weight_q        <= '0;
      weight_valid_q  <= 1'b0;
      feature_q       <= '0;
      feature_valid_q <= 1'b0;
      result_q        <= '0;
      result_valid    <= 1'b0;
      weights_loaded  <= 1'b0;
      timeout_err     <= 1'b0;
    end else begin
      weight_valid_q  <= w_hs;
      feature_valid_q <= f_hs;
      result_valid    <= (state_nx == ST_HOLD_RES);
      if (w_hs) weight_q  <= w_in_data;
      if (f_hs) feature_q <= feat_in_data;
      if (res_cap) begin
        result_q.value <= nn.max_out_NN;
        result_q.index <= nn.maxindex_out_NN;
      end
      if (start_load)                              load_pend <= 1'b0;
      else if (state == ST_HOLD_RES && load_start) load_pend <= 1'b1;
      if (start_load) wcnt <= '0;
      else if (w_hs)  wcnt <= wcnt + WCNT_W'(1);
      if (start_load)  weights_loaded <= 1'b0;
      else if (last_w) weights_loaded <= 1'b1;
      if (start_load) timeout_err <= 1'b0;
      else if (state == ST_WAIT_RES && !nn.output_valid_NN && tmo_exp_c) timeout_err <= 1'b1;
    end
  end

  har_nn_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk       (clk),
    .reset     (reset),
    .load      (state == ST_SEND_F),
    .en        (state == ST_WAIT_RES),
    .expired_c (tmo_exp_c)
  );

  assign nn.weight           = weight_q;
  assign nn.weight_valid_NN  = weight_valid_q;
  assign nn.feature          = feature_q;
  assign nn.feature_valid_NN = feature_valid_q;
  assign result_max          = result_q.value;
  assign result_index        = result_q.index;

endmodule
